// File: rtl/multiplier_pkg.sv
// Shared types and constants for the multiplier front-end and control unit.
package multiplier_pkg;

  typedef enum logic [1:0] {IDLE_UP, WAIT_DOWN, HELD_DOWN, WAIT_UP} debounce_state_t;

  localparam int KEY_CLEARA_LOADB        = 0;
  localparam int KEY_EXECUTE             = 1;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Counter width that stays legal when only a single stable cycle is required.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: synchronizer, debounce FSM with stability timer, level and edge pulses.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE_UP   | key released and accepted as released
// WAIT_DOWN | key seen pressed, waiting for it to stay pressed
// HELD_DOWN | key pressed and accepted as pressed
// WAIT_UP   | key seen released, waiting for it to stay released
module key_debouncer
  import multiplier_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  debounce_state_t        state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   pressed;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], key_n};
  assign pressed = ~sync_q[SYNC_STAGES-1];

  // Stability timer counts down from DEBOUNCE_CYCLES-1; terminal count is zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_UP: begin
        if (pressed) begin
          state_d = WAIT_DOWN;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT_DOWN: begin
        if (!pressed)             state_d = IDLE_UP;
        else if (cnt_q == '0)     state_d = HELD_DOWN;
        else                      cnt_d   = cnt_q - CNT_W'(1);
      end
      HELD_DOWN: begin
        if (!pressed) begin
          state_d = WAIT_UP;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT_UP: begin
        if (pressed)              state_d = HELD_DOWN;
        else if (cnt_q == '0)     state_d = IDLE_UP;
        else                      cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE_UP;
    endcase
  end

  // Level only rises on WAIT_DOWN->HELD_DOWN and only falls on WAIT_UP->IDLE_UP,
  // so its edges are exactly the accepted press and release events.
  always_comb begin
    level_d   = (state_q == HELD_DOWN) || (state_q == WAIT_UP);
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q    <= '1;
      state_q   <= IDLE_UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/input_conditioner.sv
// Front end of the multiplier: debounced keys, synchronized switches and a
// downstream reset that asserts asynchronously and releases synchronously.
module input_conditioner
  import multiplier_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int SW_WIDTH        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                CLK,
  input  logic                Reset_n,
  input  logic [NUM_KEYS-1:0] Key_n,
  input  logic [SW_WIDTH-1:0] SW,
  output logic [NUM_KEYS-1:0] Key_Level,
  output logic [NUM_KEYS-1:0] Key_Press,
  output logic [NUM_KEYS-1:0] Key_Release,
  output logic [SW_WIDTH-1:0] SW_Sync,
  output logic                Reset_Out
);

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_q, sw_sync_d;
  logic [SYNC_STAGES-1:0]               rst_sync_q, rst_sync_d;

  always_comb begin
    sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], SW};
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_sync_q  <= '0;
      rst_sync_q <= '1;
    end else begin
      sw_sync_q  <= sw_sync_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  assign SW_Sync   = sw_sync_q[SYNC_STAGES-1];
  assign Reset_Out = rst_sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
      .CLK         (CLK),
      .Reset_n     (Reset_n),
      .key_n       (Key_n[g]),
      .key_level   (Key_Level[g]),
      .key_press   (Key_Press[g]),
      .key_release (Key_Release[g])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce; cycle indices count
// the first edge that samples a new input as edge 0.
module tb_input_conditioner;

  localparam int NK  = 2;
  localparam int SWW = 8;
  localparam int SS  = 2;
  localparam int DC  = 4;

  logic           CLK = 1'b0;
  logic           Reset_n = 1'b0;
  logic [NK-1:0]  Key_n = '1;
  logic [SWW-1:0] SW = '0;
  logic [NK-1:0]  Key_Level, Key_Press, Key_Release;
  logic [SWW-1:0] SW_Sync;
  logic           Reset_Out;

  input_conditioner #(
    .NUM_KEYS        (NK),
    .SW_WIDTH        (SWW),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .Key_n       (Key_n),
    .SW          (SW),
    .Key_Level   (Key_Level),
    .Key_Press   (Key_Press),
    .Key_Release (Key_Release),
    .SW_Sync     (SW_Sync),
    .Reset_Out   (Reset_Out)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int press_cnt [NK];
  int rel_cnt   [NK];
  int press_cyc [NK];
  int rise_cyc  [NK];
  int fall_cyc  [NK];
  int lvl_chg   [NK];
  logic [NK-1:0] lvl_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    cyc = -1;
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0;
      rel_cnt[k]   = 0;
      press_cyc[k] = -1;
      rise_cyc[k]  = -1;
      fall_cyc[k]  = -1;
      lvl_chg[k]   = 0;
    end
    lvl_prev = Key_Level;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      cyc++;
      for (int k = 0; k < NK; k++) begin
        if (Key_Press[k]) begin
          press_cnt[k]++;
          press_cyc[k] = cyc;
        end
        if (Key_Release[k]) rel_cnt[k]++;
        if (Key_Level[k] && !lvl_prev[k]) begin
          rise_cyc[k] = cyc;
          lvl_chg[k]++;
        end
        if (!Key_Level[k] && lvl_prev[k]) begin
          fall_cyc[k] = cyc;
          lvl_chg[k]++;
        end
      end
      lvl_prev = Key_Level;
    end
  endtask

  initial begin
    // reset
    clr();
    tick(3);
    chk("rst_level",   32'(Key_Level), 0);
    chk("rst_press",   32'(Key_Press), 0);
    chk("rst_release", 32'(Key_Release), 0);
    chk("rst_sw_sync", 32'(SW_Sync), 0);
    chk("rst_out_on",  32'(Reset_Out), 1);
    Reset_n = 1'b1;
    tick(1);
    chk("rst_out_e1", 32'(Reset_Out), 1);
    tick(1);
    chk("rst_out_e2", 32'(Reset_Out), 0);

    // switches
    SW = 8'hA5;
    tick(1);
    chk("sw_e1", 32'(SW_Sync), 0);
    tick(1);
    chk("sw_e2", 32'(SW_Sync), 'hA5);

    // clean press on Execute, then clean release
    clr();
    Key_n[1] = 1'b0;
    tick(20);
    chk("clean_rise_cyc",  rise_cyc[1], 7);
    chk("clean_press_cyc", press_cyc[1], 7);
    chk("clean_press_cnt", press_cnt[1], 1);
    chk("clean_other_key", lvl_chg[0], 0);
    chk("clean_level",     32'(Key_Level), 'h2);
    Key_n[1] = 1'b1;
    tick(12);
    chk("clean_rel_cnt", rel_cnt[1], 1);
    chk("clean_level_0", 32'(Key_Level), 0);

    // bouncing ClearA_LoadB never accepted
    clr();
    Key_n[0] = 1'b0; tick(3);
    Key_n[0] = 1'b1; tick(1);
    Key_n[0] = 1'b0; tick(2);
    Key_n[0] = 1'b1; tick(15);
    chk("bounce_activity", lvl_chg[0] + press_cnt[0] + rel_cnt[0], 0);

    // boundary: DC low samples rejected, DC+1 accepted
    clr();
    Key_n[0] = 1'b0; tick(DC);
    Key_n[0] = 1'b1; tick(15);
    chk("short_press_cnt", press_cnt[0], 0);
    clr();
    Key_n[0] = 1'b0; tick(DC + 1);
    Key_n[0] = 1'b1; tick(15);
    chk("min_press_cnt", press_cnt[0], 1);
    chk("min_rel_cnt",   rel_cnt[0], 1);

    // long hold with switch change, then release with a relow glitch
    clr();
    Key_n[1] = 1'b0; tick(10);
    SW = 8'h3C;      tick(40);
    chk("hold_press_cnt", press_cnt[1], 1);
    chk("hold_rise_cyc",  rise_cyc[1], 7);
    chk("hold_sw_sync",   32'(SW_Sync), 'h3C);
    chk("hold_level",     32'(Key_Level), 'h2);
    Key_n[1] = 1'b1; tick(2);
    Key_n[1] = 1'b0; tick(2);
    Key_n[1] = 1'b1;
    cyc = -1;
    tick(15);
    chk("glitch_fall_cyc",  fall_cyc[1], 7);
    chk("glitch_rel_cnt",   rel_cnt[1], 1);
    chk("glitch_press_cnt", press_cnt[1], 1);

    // simultaneous press of both keys
    clr();
    Key_n = 2'b00;
    tick(12);
    chk("simul_press_cyc0", press_cyc[0], 7);
    chk("simul_press_cyc1", press_cyc[1], 7);
    Key_n = 2'b11;
    tick(12);
    chk("simul_rel_cnt", rel_cnt[0] + rel_cnt[1], 2);

    // reset while in WAIT_DOWN with the key still held
    clr();
    Key_n[0] = 1'b0;
    tick(4);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_out_async", 32'(Reset_Out), 1);
    tick(2);
    chk("mid_rst_no_press", press_cnt[0], 0);
    Reset_n = 1'b1;
    cyc = -1;
    tick(12);
    chk("mid_rst_press_cnt", press_cnt[0], 1);
    chk("mid_rst_press_cyc", press_cyc[0], 7);
    chk("mid_rst_out_low",   32'(Reset_Out), 0);
    Key_n = 2'b11;
    tick(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
